// File: rtl/htg_ad9213_pkg.sv
// Shared types and constants for the HTG AD9213 clock/reset blocks.
package htg_ad9213_pkg;

  typedef enum logic [2:0] {
    RESET_MMCM = 3'd0,
    WAIT_LOCK  = 3'd1,
    HOLD       = 3'd2,
    RUN        = 3'd3
  } seq_state_t;

  localparam int RETRY_CNT_WIDTH = 8;

  // Width needed to hold a terminal count of p-1; never narrower than one bit.
  function automatic int cnt_width(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/htg_ad9213_clk_rst_seq_if.sv
// MMCM-facing and status signals of the clock/reset sequencer.
interface htg_ad9213_clk_rst_seq_if #(
  parameter int CNT_WIDTH = 16
);
  import htg_ad9213_pkg::*;

  logic                       mmcm_locked;
  logic                       cnt_clr;
  logic                       mmcm_rst;
  logic                       user_rst_n;
  logic                       clk_ready;
  logic [CNT_WIDTH-1:0]       lock_loss_cnt;
  logic [RETRY_CNT_WIDTH-1:0] retry_cnt;
  logic [2:0]                 state_o;

  modport master (
    input  mmcm_locked, cnt_clr,
    output mmcm_rst, user_rst_n, clk_ready, lock_loss_cnt, retry_cnt, state_o
  );

  modport slave (
    output mmcm_locked, cnt_clr,
    input  mmcm_rst, user_rst_n, clk_ready, lock_loss_cnt, retry_cnt, state_o
  );

endinterface

// File: rtl/htg_ad9213_sync2.sv
// Generic two-flop synchronizer with synchronous active-low reset.
module htg_ad9213_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      (* ASYNC_REG = "TRUE" *) logic meta_reg;
      (* ASYNC_REG = "TRUE" *) logic sync_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= d[gi];
          sync_reg <= meta_reg;
        end
      end

      assign q[gi] = sync_reg;
    end
  endgenerate

endmodule

// File: rtl/htg_ad9213_clk_rst_seq.sv
// MMCM reset/lock sequencer: pulses the MMCM reset, qualifies LOCKED, and
// releases a clean downstream reset; retries on lock timeout.
module htg_ad9213_clk_rst_seq
  import htg_ad9213_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RST_HOLD_CYCLES     = 256,
  parameter int LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int MMCM_RST_CYCLES     = 16,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  htg_ad9213_clk_rst_seq_if.master  bus
);

  localparam int STABLE_W = cnt_width(LOCK_STABLE_CYCLES);
  localparam int HOLD_W   = cnt_width(RST_HOLD_CYCLES);
  localparam int WAIT_W   = cnt_width(LOCK_TIMEOUT_CYCLES);
  localparam int RST_W    = cnt_width(MMCM_RST_CYCLES);

  localparam logic [STABLE_W-1:0] STABLE_TC = STABLE_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]   HOLD_TC   = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [WAIT_W-1:0]   WAIT_TC   = WAIT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RST_W-1:0]    RST_TC    = RST_W'(MMCM_RST_CYCLES - 1);

  seq_state_t state_reg, state_next;

  logic [STABLE_W-1:0]        stable_cnt_reg;
  logic [HOLD_W-1:0]          hold_cnt_reg;
  logic [WAIT_W-1:0]          wait_cnt_reg;
  logic [RST_W-1:0]           rst_cnt_reg;
  logic [CNT_WIDTH-1:0]       lock_loss_cnt_reg;
  logic [RETRY_CNT_WIDTH-1:0] retry_cnt_reg;
  logic                       mmcm_rst_reg;
  logic                       user_rst_n_reg;
  logic                       clk_ready_reg;

  logic locked_s;
  logic retry_inc;
  logic loss_inc;

  htg_ad9213_sync2 #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.mmcm_locked),
    .q     (locked_s)
  );

  always_comb begin
    state_next = state_reg;
    retry_inc  = 1'b0;
    loss_inc   = 1'b0;
    case (state_reg)
      RESET_MMCM: begin
        if (rst_cnt_reg == RST_TC) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Qualification takes priority over a coincident timeout.
        if (locked_s && (stable_cnt_reg == STABLE_TC)) begin
          state_next = HOLD;
        end else if (wait_cnt_reg == WAIT_TC) begin
          state_next = RESET_MMCM;
          retry_inc  = 1'b1;
        end
      end
      HOLD: begin
        if (!locked_s)                   state_next = WAIT_LOCK;
        else if (hold_cnt_reg == HOLD_TC) state_next = RUN;
      end
      RUN: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          loss_inc   = 1'b1;
        end
      end
      default: state_next = RESET_MMCM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= RESET_MMCM;
      stable_cnt_reg <= '0;
      hold_cnt_reg   <= '0;
      wait_cnt_reg   <= '0;
      rst_cnt_reg    <= '0;
      mmcm_rst_reg   <= 1'b1;
      user_rst_n_reg <= 1'b0;
      clk_ready_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      mmcm_rst_reg   <= (state_next == RESET_MMCM);
      user_rst_n_reg <= (state_next == RUN);
      clk_ready_reg  <= (state_next == RUN);
      // Every state timer starts from zero on entry to any state.
      if (state_next != state_reg) begin
        stable_cnt_reg <= '0;
        hold_cnt_reg   <= '0;
        wait_cnt_reg   <= '0;
        rst_cnt_reg    <= '0;
      end else begin
        case (state_reg)
          RESET_MMCM: rst_cnt_reg <= rst_cnt_reg + 1'b1;
          WAIT_LOCK: begin
            wait_cnt_reg   <= wait_cnt_reg + 1'b1;
            stable_cnt_reg <= locked_s ? stable_cnt_reg + 1'b1 : '0;
          end
          HOLD:    hold_cnt_reg <= hold_cnt_reg + 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Status counters saturate; a clear coinciding with an event keeps that event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_loss_cnt_reg <= '0;
      retry_cnt_reg     <= '0;
    end else begin
      if (bus.cnt_clr)
        lock_loss_cnt_reg <= CNT_WIDTH'(loss_inc);
      else if (loss_inc && (lock_loss_cnt_reg != '1))
        lock_loss_cnt_reg <= lock_loss_cnt_reg + 1'b1;

      if (bus.cnt_clr)
        retry_cnt_reg <= RETRY_CNT_WIDTH'(retry_inc);
      else if (retry_inc && (retry_cnt_reg != '1))
        retry_cnt_reg <= retry_cnt_reg + 1'b1;
    end
  end

  assign bus.mmcm_rst      = mmcm_rst_reg;
  assign bus.user_rst_n    = user_rst_n_reg;
  assign bus.clk_ready     = clk_ready_reg;
  assign bus.lock_loss_cnt = lock_loss_cnt_reg;
  assign bus.retry_cnt     = retry_cnt_reg;
  assign bus.state_o       = state_reg;

endmodule

// File: tb/tb_htg_ad9213_clk_rst_seq.sv
// Directed self-checking bench for the AD9213 clock/reset sequencer.
module tb_htg_ad9213_clk_rst_seq;

  localparam int L  = 16;
  localparam int H  = 8;
  localparam int T  = 100;
  localparam int R  = 4;
  localparam int CW = 16;
  localparam int RISE_EDGES = 2 + L + H;  // 26
  localparam int FALL_EDGES = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  htg_ad9213_clk_rst_seq_if #(.CNT_WIDTH(CW)) bus ();

  htg_ad9213_clk_rst_seq #(
    .LOCK_STABLE_CYCLES  (L),
    .RST_HOLD_CYCLES     (H),
    .LOCK_TIMEOUT_CYCLES (T),
    .MMCM_RST_CYCLES     (R),
    .CNT_WIDTH           (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges until user_rst_n reaches level, counting the first edge after the call as 1.
  task automatic edges_until_urst(input logic level, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.user_rst_n !== level && n < limit);
  endtask

  task automatic test_reset();
    logic exp_rst;
    rst_n = 1'b0;
    bus.mmcm_locked = 1'b0;
    bus.cnt_clr = 1'b0;
    repeat (3) tick();
    total++;
    if (bus.mmcm_rst !== 1'b1 || bus.user_rst_n !== 1'b0 || bus.clk_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: mmcm_rst=%b user_rst_n=%b clk_ready=%b, expected 1 0 0",
               bus.mmcm_rst, bus.user_rst_n, bus.clk_ready);
    end
    total++;
    if (bus.state_o !== 3'd0 || bus.lock_loss_cnt !== 16'd0 || bus.retry_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_state: state=%0d loss=%0d retry=%0d, expected 0 0 0",
               bus.state_o, bus.lock_loss_cnt, bus.retry_cnt);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= R; i++) begin
      tick();
      exp_rst = (i < R);
      total++;
      if (bus.mmcm_rst !== exp_rst) begin
        bad++;
        $display("FAIL mmcm_rst_pulse edge %0d: got %b expected %b", i, bus.mmcm_rst, exp_rst);
      end
    end
    total++;
    if (bus.state_o !== 3'd1) begin
      bad++;
      $display("FAIL enter_wait_lock: state=%0d expected 1", bus.state_o);
    end
    $display("reset: mmcm_rst pulse released, state=%0d", bus.state_o);
  endtask

  task automatic test_lock_rise();
    int n;
    bus.mmcm_locked = 1'b1;
    edges_until_urst(1'b1, 200, n);
    total++;
    if (n !== RISE_EDGES) begin
      bad++;
      $display("FAIL rise_latency: got %0d edges expected %0d", n, RISE_EDGES);
    end
    total++;
    if (bus.clk_ready !== 1'b1 || bus.state_o !== 3'd3 || bus.mmcm_rst !== 1'b0) begin
      bad++;
      $display("FAIL run_outputs: clk_ready=%b state=%0d mmcm_rst=%b, expected 1 3 0",
               bus.clk_ready, bus.state_o, bus.mmcm_rst);
    end
    $display("lock_rise: user_rst_n after %0d edges", n);
  endtask

  task automatic test_lock_loss();
    int n;
    total++;
    if (bus.lock_loss_cnt !== 16'd0) begin
      bad++;
      $display("FAIL loss_cnt_before: got %0d expected 0", bus.lock_loss_cnt);
    end
    bus.mmcm_locked = 1'b0;
    edges_until_urst(1'b0, 50, n);
    total++;
    if (n !== FALL_EDGES || bus.clk_ready !== 1'b0) begin
      bad++;
      $display("FAIL fall_latency: got %0d edges clk_ready=%b expected %0d edges clk_ready=0",
               n, bus.clk_ready, FALL_EDGES);
    end
    total++;
    if (bus.lock_loss_cnt !== 16'd1 || bus.state_o !== 3'd1) begin
      bad++;
      $display("FAIL loss_count: loss=%0d state=%0d expected 1 1", bus.lock_loss_cnt, bus.state_o);
    end
    bus.mmcm_locked = 1'b1;
    edges_until_urst(1'b1, 200, n);
    total++;
    if (n !== RISE_EDGES || bus.clk_ready !== 1'b1) begin
      bad++;
      $display("FAIL relock_latency: got %0d edges clk_ready=%b expected %0d edges clk_ready=1",
               n, bus.clk_ready, RISE_EDGES);
    end
    $display("lock_loss: fall and relock done, loss=%0d", bus.lock_loss_cnt);
  endtask

  task automatic test_glitch();
    int n;
    bus.mmcm_locked = 1'b0;
    repeat (FALL_EDGES) tick();
    total++;
    if (bus.lock_loss_cnt !== 16'd2 || bus.state_o !== 3'd1) begin
      bad++;
      $display("FAIL glitch_setup: loss=%0d state=%0d expected 2 1", bus.lock_loss_cnt, bus.state_o);
    end
    bus.mmcm_locked = 1'b1;
    repeat (12) tick();
    bus.mmcm_locked = 1'b0;
    tick();
    bus.mmcm_locked = 1'b1;
    edges_until_urst(1'b1, 200, n);
    total++;
    if (n !== RISE_EDGES) begin
      bad++;
      $display("FAIL glitch_restart: got %0d edges expected %0d", n, RISE_EDGES);
    end
    $display("glitch: stable count restarted, user_rst_n after %0d edges", n);
  endtask

  task automatic test_retry();
    int   n;
    int   rises;
    logic prev;
    bus.mmcm_locked = 1'b0;
    repeat (FALL_EDGES) tick();
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.mmcm_rst !== 1'b1 && n < 300);
    total++;
    if (n !== T || bus.retry_cnt !== 8'd1) begin
      bad++;
      $display("FAIL timeout: got %0d edges retry=%0d expected %0d edges retry=1", n, bus.retry_cnt, T);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.mmcm_rst === 1'b1 && n < 50);
    total++;
    if (n !== R || bus.state_o !== 3'd1) begin
      bad++;
      $display("FAIL retry_pulse: got %0d cycles state=%0d expected %0d cycles state=1",
               n, bus.state_o, R);
    end
    rises = 1;
    prev  = bus.mmcm_rst;
    for (int c = 0; c < 299 * (T + R) + 500 && rises < 300; c++) begin
      tick();
      if (bus.mmcm_rst === 1'b1 && prev === 1'b0) rises++;
      prev = bus.mmcm_rst;
    end
    total++;
    if (rises !== 300 || bus.retry_cnt !== 8'd255) begin
      bad++;
      $display("FAIL retry_saturate: retries=%0d retry=%0d expected 300 255", rises, bus.retry_cnt);
    end
    repeat (T + R - 1) tick();
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    total++;
    if (bus.mmcm_rst !== 1'b1 || bus.retry_cnt !== 8'd1 || bus.lock_loss_cnt !== 16'd0) begin
      bad++;
      $display("FAIL clr_with_retry: mmcm_rst=%b retry=%0d loss=%0d expected 1 1 0",
               bus.mmcm_rst, bus.retry_cnt, bus.lock_loss_cnt);
    end
    $display("retry: %0d retries seen, retry=%0d after clear", rises, bus.retry_cnt);
  endtask

  task automatic test_midrun_reset();
    int n;
    bus.mmcm_locked = 1'b1;
    edges_until_urst(1'b1, 200, n);
    total++;
    if (bus.clk_ready !== 1'b1) begin
      bad++;
      $display("FAIL reach_run: clk_ready=%b after %0d edges expected 1", bus.clk_ready, n);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (bus.user_rst_n !== 1'b0 || bus.clk_ready !== 1'b0 || bus.mmcm_rst !== 1'b1) begin
      bad++;
      $display("FAIL midrun_reset_outputs: user_rst_n=%b clk_ready=%b mmcm_rst=%b expected 0 0 1",
               bus.user_rst_n, bus.clk_ready, bus.mmcm_rst);
    end
    total++;
    if (bus.state_o !== 3'd0 || bus.retry_cnt !== 8'd0 || bus.lock_loss_cnt !== 16'd0) begin
      bad++;
      $display("FAIL midrun_reset_state: state=%0d retry=%0d loss=%0d expected 0 0 0",
               bus.state_o, bus.retry_cnt, bus.lock_loss_cnt);
    end
    $display("midrun_reset: state=%0d mmcm_rst=%b", bus.state_o, bus.mmcm_rst);
  endtask

  initial begin
    test_reset();
    test_lock_rise();
    test_lock_loss();
    test_glitch();
    test_retry();
    test_midrun_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
